// File: rtl/arilla_ram_responder.sv
// Arilla bus target: single-port word RAM with address-window decode,
// programmable wait states and a one-cycle registered ack pulse.
module arilla_ram_responder #(
    parameter int                      DataWidth    = 32,
    parameter int                      AddressWidth = 32,
    parameter logic [AddressWidth-1:0] BaseAddress  = '0,
    parameter int                      SizeBytes    = 4096,
    parameter int                      WaitStates   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddressWidth-1:0] bus_addr,
    input  logic [DataWidth-1:0]    bus_wdata,
    input  logic [3:0]              bus_be,
    input  logic                    bus_rd,
    input  logic                    bus_wr,
    output logic                    bus_hit,
    output logic [DataWidth-1:0]    bus_rdata,
    output logic                    bus_ack
);

    localparam int Depth      = SizeBytes / 4;
    localparam int IndexWidth = (SizeBytes > 4) ? $clog2(SizeBytes) - 2 : 1;
    localparam logic [AddressWidth-1:0] WindowMask = ~(AddressWidth'(SizeBytes - 1));
    localparam logic [3:0] WaitInit = (WaitStates == 0) ? 4'd0 : 4'(WaitStates - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             count_q, count_d;
    logic [IndexWidth-1:0]  idx_q, idx_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic                   is_write_q, is_write_d;
    logic                   ack_q, ack_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;

    logic [DataWidth-1:0]    mem [Depth];
    logic [AddressWidth-1:0] addr_off;
    logic [IndexWidth-1:0]   req_idx;
    logic                    accept;
    logic                    unused_addr;

    // The window is aligned to its size, so a masked compare decodes it without overflow.
    assign bus_hit     = (bus_addr & WindowMask) == BaseAddress;
    assign addr_off    = bus_addr - BaseAddress;
    assign req_idx     = addr_off[IndexWidth+1:2];
    assign accept      = bus_hit && (bus_rd ^ bus_wr);
    assign unused_addr = ^addr_off;

    assign bus_ack   = ack_q;
    assign bus_rdata = rdata_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        is_write_d = is_write_q;
        ack_d      = 1'b0;
        rdata_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d      = req_idx;
                    wdata_d    = bus_wdata;
                    be_d       = bus_be;
                    is_write_d = bus_wr;
                    if (WaitStates == 0) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        if (!bus_wr) begin
                            rdata_d = mem[req_idx];
                        end
                    end else begin
                        state_d = S_WAIT;
                        count_d = WaitInit;
                    end
                end
            end
            S_WAIT: begin
                if (count_q == 4'd0) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (!is_write_q) begin
                        rdata_d = mem[idx_q];
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            is_write_q <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            is_write_q <= is_write_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    // Writes commit on the edge that ends ACK; a reset on that edge drops them.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_ACK && is_write_q) begin
            for (int n = 0; n < 4; n++) begin
                if (be_q[n]) begin
                    mem[idx_q][8*n +: 8] <= wdata_q[8*n +: 8];
                end
            end
        end
    end

endmodule
